fifo_ctrl_4x8: RTL and testbench

Pointer and flag controller that drives the 4x8 memory as a synchronous FIFO. It is the producer/consumer-facing end of the memory's `read`/`write`/`wr_ptr`/`rd_ptr`/`data_in` interface. It generates those signals from upstream push and downstream pop requests, tracks occupancy, and returns read data with a valid strobe. One instance sits in front of each memory in the switch's buffering path.

---
 rtl/fifo_ctrl_4x8_pkg.sv | 31 +++
 rtl/fifo_ptr_wrap.sv | 21 ++
 rtl/fifo_ctrl_4x8.sv | 98 +++++++++
 tb/tb_fifo_ctrl_4x8.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_4x8_pkg.sv
// rtl/fifo_ctrl_4x8_pkg.sv - shared defaults and count-update helper for the FIFO controller
package fifo_ctrl_4x8_pkg;

    localparam int DEF_MAIN_SIZE = 4;
    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_MEM_DEPTH = 4;
    localparam int DEF_AF_THRESH = 3;
    localparam int DEF_AE_THRESH = 1;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    function automatic int count_width(input int main_size);
        return main_size + 1;
    endfunction

    // Push and pop in the same cycle cancel out
    function automatic cnt_op_e cnt_op(input logic push_acc, input logic pop_acc);
        cnt_op_e op;
        op = CNT_HOLD;
        if (push_acc && !pop_acc)
            op = CNT_INC;
        else if (pop_acc && !push_acc)
            op = CNT_DEC;
        return op;
    endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// rtl/fifo_ptr_wrap.sv - wrapping memory pointer register
module fifo_ptr_wrap #(
    parameter int MAIN_SIZE = 4,
    parameter int MEM_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [MAIN_SIZE-1:0] ptr
);

    localparam logic [MAIN_SIZE-1:0] LAST = MAIN_SIZE'(MEM_DEPTH - 1);

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/fifo_ctrl_4x8.sv
// rtl/fifo_ctrl_4x8.sv - push/pop pointer and flag controller driving the 4x8 memory as a FIFO
module fifo_ctrl_4x8
    import fifo_ctrl_4x8_pkg::*;
#(
    parameter int MAIN_SIZE = DEF_MAIN_SIZE,
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 pop,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [MAIN_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic [MAIN_SIZE-1:0] mem_wr_ptr,
    output logic [MAIN_SIZE-1:0] mem_rd_ptr,
    output logic [DATA_SIZE-1:0] mem_data_in,
    input  logic [DATA_SIZE-1:0] mem_data_out
);

    localparam int CW = count_width(MAIN_SIZE);

    logic                 push_acc;
    logic                 pop_acc;
    logic [MAIN_SIZE-1:0] wr_ptr;
    logic [MAIN_SIZE-1:0] rd_ptr;

    assign push_acc = push && !full;
    assign pop_acc  = pop && !empty;

    // Strobes are gated by reset so a stale request cannot corrupt memory
    assign mem_write   = push_acc && !reset;
    assign mem_read    = pop_acc && !reset;
    assign mem_wr_ptr  = wr_ptr;
    assign mem_rd_ptr  = rd_ptr;
    assign mem_data_in = data_in;

    fifo_ptr_wrap #(
        .MAIN_SIZE(MAIN_SIZE),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_wr_ptr (
        .clk  (clk),
        .reset(reset),
        .inc  (mem_write),
        .ptr  (wr_ptr)
    );

    fifo_ptr_wrap #(
        .MAIN_SIZE(MAIN_SIZE),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_rd_ptr (
        .clk  (clk),
        .reset(reset),
        .inc  (mem_read),
        .ptr  (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (cnt_op(push_acc, pop_acc))
                CNT_INC: count <= count + 1'b1;
                CNT_DEC: count <= count - 1'b1;
                default: count <= count;
            endcase
            valid <= pop_acc;
            if (push && full)
                overflow <= 1'b1;
            if (pop && empty)
                underflow <= 1'b1;
        end
    end

    assign full         = (count == CW'(MEM_DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    // Memory read data is already registered, so it lines up with valid
    assign data_out = valid ? mem_data_out : '0;

endmodule

// File: tb/tb_fifo_ctrl_4x8.sv
// tb/tb_fifo_ctrl_4x8.sv - self-checking bench for fifo_ctrl_4x8 with a 4x8 memory model
module tb_fifo_ctrl_4x8;

    logic       clk;
    logic       reset;
    logic       push;
    logic [7:0] data_in;
    logic       pop;
    logic [7:0] data_out;
    logic       valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       mem_write;
    logic       mem_read;
    logic [3:0] mem_wr_ptr;
    logic [3:0] mem_rd_ptr;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;

    logic [7:0] mem [0:3];

    int checks;
    int failures;

    fifo_ctrl_4x8 dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .data_in     (data_in),
        .pop         (pop),
        .data_out    (data_out),
        .valid       (valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .mem_wr_ptr  (mem_wr_ptr),
        .mem_rd_ptr  (mem_rd_ptr),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_write)
            mem[mem_wr_ptr[1:0]] <= mem_data_in;
        if (mem_read)
            mem_data_out <= mem[mem_rd_ptr[1:0]];
    end

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] din;
        logic       mw;
        logic       mr;
        logic [3:0] wp;
        logic [3:0] rp;
        logic [4:0] cnt;
        logic       vld;
        logic [7:0] dout;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic p, input logic q, input logic [7:0] d,
                                input logic mw, input logic mr, input int wp, input int rp,
                                input int cnt, input logic vld, input logic [7:0] dout,
                                input logic ovf, input logic udf);
        vec_t v;
        v.push = p;  v.pop = q;  v.din = d;
        v.mw = mw;   v.mr = mr;  v.wp = 4'(wp); v.rp = 4'(rp);
        v.cnt = 5'(cnt); v.vld = vld; v.dout = dout;
        v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        push = v.push;
        pop = v.pop;
        data_in = v.din;
        #1;
        chk({tag, " mem_write"}, int'(mem_write), int'(v.mw));
        chk({tag, " mem_read"}, int'(mem_read), int'(v.mr));
        chk({tag, " mem_wr_ptr"}, int'(mem_wr_ptr), int'(v.wp));
        chk({tag, " mem_rd_ptr"}, int'(mem_rd_ptr), int'(v.rp));
        @(posedge clk);
        #1;
        chk({tag, " count"}, int'(count), int'(v.cnt));
        chk({tag, " full"}, int'(full), int'(v.cnt == 5'd4));
        chk({tag, " empty"}, int'(empty), int'(v.cnt == 5'd0));
        chk({tag, " almost_full"}, int'(almost_full), int'(v.cnt >= 5'd3));
        chk({tag, " almost_empty"}, int'(almost_empty), int'(v.cnt <= 5'd1));
        chk({tag, " valid"}, int'(valid), int'(v.vld));
        if (v.vld)
            chk({tag, " data_out"}, int'(data_out), int'(v.dout));
        chk({tag, " overflow"}, int'(overflow), int'(v.ovf));
        chk({tag, " underflow"}, int'(underflow), int'(v.udf));
        push = 1'b0;
        pop = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        push = 1'b0;
        pop = 1'b0;
        data_in = 8'h00;

        // fill then overflow
        vecs.push_back(mk(1, 0, 8'hFF, 1, 0, 0, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 8'hDD, 1, 0, 1, 0, 2, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 8'hEE, 1, 0, 2, 0, 3, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 8'hCC, 1, 0, 3, 0, 4, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 8'hBB, 0, 0, 0, 0, 4, 0, 8'h00, 1, 0));
        // drain then underflow
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 3, 1, 8'hFF, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 0, 1, 2, 1, 8'hDD, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 0, 2, 1, 1, 8'hEE, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 0, 3, 0, 1, 8'hCC, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 1));
        // wrap-around with alternating push/pop
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk(1, 0, 8'(8'h90 + i), 1, 0, i % 4, i % 4, 1, 0, 8'h00, 1, 1));
            vecs.push_back(mk(0, 1, 8'h00, 0, 1, (i + 1) % 4, i % 4, 0, 1, 8'(8'h90 + i), 1, 1));
        end
        // simultaneous push and pop at count 2
        vecs.push_back(mk(1, 0, 8'h11, 1, 0, 2, 2, 1, 0, 8'h00, 1, 1));
        vecs.push_back(mk(1, 0, 8'h22, 1, 0, 3, 2, 2, 0, 8'h00, 1, 1));
        vecs.push_back(mk(1, 1, 8'hAA, 1, 1, 0, 2, 2, 1, 8'h11, 1, 1));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 1, 3, 1, 1, 8'h22, 1, 1));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 1, 0, 0, 1, 8'hAA, 1, 1));

        // reset held 6 cycles
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rst empty", int'(empty), 1);
        chk("rst count", int'(count), 0);
        chk("rst mem_write", int'(mem_write), 0);
        chk("rst mem_read", int'(mem_read), 0);
        chk("rst overflow", int'(overflow), 0);
        chk("rst underflow", int'(underflow), 0);
        chk("rst valid", int'(valid), 0);
        chk("rst data_out", int'(data_out), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post-rst empty", int'(empty), 1);
        chk("post-rst count", int'(count), 0);
        chk("post-rst almost_empty", int'(almost_empty), 1);
        chk("post-rst overflow", int'(overflow), 0);
        chk("post-rst underflow", int'(underflow), 0);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], $sformatf("vec%0d", i));

        // push+pop on empty: push taken, pop rejected with underflow
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step(mk(1, 1, 8'h88, 1, 0, 0, 0, 1, 0, 8'h00, 0, 1), "empty-pp");
        step(mk(1, 0, 8'h44, 1, 0, 1, 0, 2, 0, 8'h00, 0, 1), "fill44");
        step(mk(1, 0, 8'h55, 1, 0, 2, 0, 3, 0, 8'h00, 0, 1), "fill55");
        step(mk(1, 1, 8'h66, 1, 1, 3, 0, 3, 1, 8'h88, 0, 1), "pp66");

        // reset during a push at count 3
        @(negedge clk);
        reset = 1'b1;
        push = 1'b1;
        data_in = 8'h77;
        #1;
        chk("midrst mem_write", int'(mem_write), 0);
        chk("midrst mem_read", int'(mem_read), 0);
        @(posedge clk);
        #1;
        chk("midrst count", int'(count), 0);
        chk("midrst empty", int'(empty), 1);
        chk("midrst wr_ptr", int'(mem_wr_ptr), 0);
        chk("midrst rd_ptr", int'(mem_rd_ptr), 0);
        chk("midrst valid", int'(valid), 0);
        chk("midrst underflow", int'(underflow), 0);
        @(negedge clk);
        reset = 1'b0;
        push = 1'b0;
        step(mk(1, 0, 8'hBB, 1, 0, 0, 0, 1, 0, 8'h00, 0, 0), "after-rst push");
        step(mk(0, 1, 8'h00, 0, 1, 1, 0, 0, 1, 8'hBB, 0, 0), "after-rst pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
